// File: rtl/range_stream_if.sv
// ============================================================================
//  Module      : range_stream_if
//  Description : Host load/control bus and go/finish/data sample-stream bus
//                of the range-stream transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface range_stream_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clear;
    logic             start;
    logic [CW-1:0]    count;
    logic             full;
    logic             busy;
    logic             done;
    logic             wr_err;
    logic             start_err;
    logic             go;
    logic             finish;
    logic [WIDTH-1:0] data_out;

    modport master (
        output wr_en, wr_data, clear, start,
        input  count, full, busy, done, wr_err, start_err, go, finish, data_out
    );

    modport slave (
        input  wr_en, wr_data, clear, start,
        output count, full, busy, done, wr_err, start_err, go, finish, data_out
    );
endinterface

`default_nettype wire

// File: rtl/range_stream_tx.sv
// ============================================================================
//  Module      : range_stream_tx
//  Description : Buffers a burst of samples and replays it one per cycle as
//                go/finish/data_out to the range-finder receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module range_stream_tx #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  wire logic       clock,
    input  wire logic       reset,
    range_stream_if.slave   bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [WIDTH-1:0] buf_d [DEPTH];
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_err_q, wr_err_d;
    logic             start_err_q, start_err_d;
    logic             go_q, go_d;
    logic             finish_q, finish_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic [CW1-1:0]   nxt_idx;
    logic             is_last;
    logic             is_pre_last;

    // rd_ptr_q is the index of the sample currently on data_out.
    assign nxt_idx     = CW1'(rd_ptr_q) + CW1'(1);
    assign is_last     = (nxt_idx == CW1'(count_q));
    assign is_pre_last = ((nxt_idx + CW1'(1)) == CW1'(count_q));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        buf_d       = buf_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wr_err_d    = 1'b0;
        start_err_d = 1'b0;
        go_d        = 1'b0;
        finish_d    = 1'b0;
        data_out_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    count_d = '0;
                end else if (bus.wr_en) begin
                    if (count_q == CW'(DEPTH)) begin
                        wr_err_d = 1'b1;
                    end else begin
                        buf_d[count_q[PW-1:0]] = bus.wr_data;
                        count_d                = count_q + CW'(1);
                    end
                end
                // count_d already includes a write accepted this cycle.
                if (bus.start) begin
                    if (count_d == '0) begin
                        start_err_d = 1'b1;
                    end else begin
                        state_d    = SEND;
                        busy_d     = 1'b1;
                        go_d       = 1'b1;
                        rd_ptr_d   = '0;
                        data_out_d = (count_q == '0) ? bus.wr_data : buf_q[0];
                    end
                end
            end

            SEND: begin
                wr_err_d = bus.wr_en;
                if (is_last) begin
                    if (count_q == CW'(1)) begin
                        // Single-sample burst: repeat it with finish so go and
                        // finish never share a cycle.
                        state_d    = HOLD;
                        finish_d   = 1'b1;
                        data_out_d = data_out_q;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        count_d = '0;
                    end
                end else begin
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                    data_out_d = buf_q[nxt_idx[PW-1:0]];
                    finish_d   = is_pre_last;
                end
            end

            HOLD: begin
                wr_err_d = bus.wr_en;
                state_d  = IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                count_d  = '0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            start_err_q <= 1'b0;
            go_q        <= 1'b0;
            finish_q    <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
            start_err_q <= start_err_d;
            go_q        <= go_d;
            finish_q    <= finish_d;
            data_out_q  <= data_out_d;
        end
    end

    // Sample storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clock) begin
        buf_q <= buf_d;
    end

    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.start_err = start_err_q;
    assign bus.go        = go_q;
    assign bus.finish    = finish_q;
    assign bus.data_out  = data_out_q;
endmodule

`default_nettype wire

// File: tb/tb_range_stream_tx.sv
// ============================================================================
//  Module      : tb_range_stream_tx
//  Description : Directed vector-table bench for range_stream_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_range_stream_tx;
    localparam int WIDTH = 2;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    range_stream_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    range_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       wr_en;
        logic [1:0] wr_data;
        logic       clear;
        logic       start;
    } in_t;

    typedef struct packed {
        logic [3:0] count;
        logic       full;
        logic       busy;
        logic       done;
        logic       wr_err;
        logic       start_err;
        logic       go;
        logic       finish;
        logic [1:0] data;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic out_t mk(int cnt, bit busy, bit done, bit werr, bit serr,
                                bit go, bit fin, int d);
        out_t o;
        o.count     = 4'(cnt);
        o.full      = (cnt == DEPTH);
        o.busy      = busy;
        o.done      = done;
        o.wr_err    = werr;
        o.start_err = serr;
        o.go        = go;
        o.finish    = fin;
        o.data      = 2'(d);
        return o;
    endfunction

    function automatic out_t idl(int cnt);
        return mk(cnt, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic out_t snd(int cnt, bit go, bit fin, int d);
        return mk(cnt, 1, 0, 0, 0, go, fin, d);
    endfunction

    function automatic void add(string name, bit we, int wd, bit clr, bit st, out_t e);
        vec_t v;
        v.name          = name;
        v.in.wr_en      = we;
        v.in.wr_data    = 2'(wd);
        v.in.clear      = clr;
        v.in.start      = st;
        v.exp           = e;
        vecs.push_back(v);
    endfunction

    function automatic out_t sample();
        out_t a;
        a.count     = bus.count;
        a.full      = bus.full;
        a.busy      = bus.busy;
        a.done      = bus.done;
        a.wr_err    = bus.wr_err;
        a.start_err = bus.start_err;
        a.go        = bus.go;
        a.finish    = bus.finish;
        a.data      = bus.data_out;
        return a;
    endfunction

    task automatic check(string name, out_t exp);
        out_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual cnt/full/busy/done/werr/serr/go/fin/data=%h required=%h",
                     name, act, exp);
        end
    endtask

    task automatic drive(bit we, int wd, bit clr, bit st);
        bus.wr_en   = we;
        bus.wr_data = 2'(wd);
        bus.clear   = clr;
        bus.start   = st;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0);

        // Four-sample burst 1,3,0,2.
        add("w1", 1, 1, 0, 0, idl(1));
        add("w3", 1, 3, 0, 0, idl(2));
        add("w0", 1, 0, 0, 0, idl(3));
        add("w2", 1, 2, 0, 0, idl(4));
        add("b4_k1", 0, 0, 0, 1, snd(4, 1, 0, 1));
        add("b4_k2", 0, 0, 0, 0, snd(4, 0, 0, 3));
        add("b4_k3", 0, 0, 0, 0, snd(4, 0, 0, 0));
        add("b4_k4", 0, 0, 0, 0, snd(4, 0, 1, 2));
        add("b4_done", 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0));
        add("b4_idle", 0, 0, 0, 0, idl(0));

        // Single-sample burst uses the hold cycle.
        add("s_w2", 1, 2, 0, 0, idl(1));
        add("b1_k1", 0, 0, 0, 1, snd(1, 1, 0, 2));
        add("b1_k2", 0, 0, 0, 0, snd(1, 0, 1, 2));
        add("b1_done", 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0));

        // Start on empty buffer, issued in the done cycle.
        add("start_at_done", 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 0));
        add("after_serr", 0, 0, 0, 0, idl(0));

        // Overflow and full-depth burst.
        for (int i = 0; i < DEPTH; i++)
            add($sformatf("fill%0d", i), 1, i % 4, 0, 0, idl(i + 1));
        add("overflow", 1, 3, 0, 0, mk(DEPTH, 0, 0, 1, 0, 0, 0, 0));
        add("b8_k1", 0, 0, 0, 1, snd(DEPTH, 1, 0, 0));
        for (int k = 2; k <= DEPTH; k++)
            add($sformatf("b8_k%0d", k), 0, 0, 0, 0, snd(DEPTH, 0, k == DEPTH, (k - 1) % 4));
        add("b8_done", 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0));
        add("b8_idle", 0, 0, 0, 0, idl(0));

        // Write/start/clear during SEND must not disturb the burst.
        add("m_w0", 1, 0, 0, 0, idl(1));
        add("m_w1", 1, 1, 0, 0, idl(2));
        add("m_w2", 1, 2, 0, 0, idl(3));
        add("m_k1", 0, 0, 0, 1, snd(3, 1, 0, 0));
        add("m_k2_werr", 1, 3, 1, 1, mk(3, 1, 0, 1, 0, 0, 0, 1));
        add("m_k3", 0, 0, 0, 0, snd(3, 0, 1, 2));
        add("m_done", 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0));

        // Clear beats a same-cycle write.
        add("c_w1", 1, 1, 0, 0, idl(1));
        add("c_w2", 1, 2, 0, 0, idl(2));
        add("c_clear", 1, 3, 1, 0, idl(0));
        add("c_start", 0, 0, 0, 1, mk(0, 0, 0, 0, 1, 0, 0, 0));

        // Write accepted with start becomes the last sample.
        add("ws_w0", 1, 0, 0, 0, idl(1));
        add("ws_w1", 1, 1, 0, 0, idl(2));
        add("ws_k1", 1, 3, 0, 1, snd(3, 1, 0, 0));
        add("ws_k2", 0, 0, 0, 0, snd(3, 0, 0, 1));
        add("ws_k3", 0, 0, 0, 0, snd(3, 0, 1, 3));
        add("ws_done", 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0));
        add("ws_idle", 0, 0, 0, 0, idl(0));

        // Reset state.
        step();
        step();
        check("reset_state", idl(0));
        @(negedge clock);
        reset = 1'b0;
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].in.wr_en, int'(vecs[i].in.wr_data), vecs[i].in.clear, vecs[i].in.start);
            step();
            check(vecs[i].name, vecs[i].exp);
        end
        drive(0, 0, 0, 0);

        // Asynchronous reset while finish is high at k=2.
        drive(1, 1, 0, 0);
        step();
        drive(1, 3, 0, 0);
        step();
        drive(0, 0, 0, 1);
        step();
        check("r_k1", snd(2, 1, 0, 1));
        drive(0, 0, 0, 0);
        step();
        check("r_k2", snd(2, 0, 1, 3));
        reset = 1'b1;
        #1;
        check("r_async", idl(0));
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("r_nodone%0d", i), idl(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
